// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache between warp scheduler and decode.
// Single-cycle hits; misses fetch a whole line over a request/burst-response memory port.
module icache_direct_mapped #(
    parameter int unsigned WARP_ID_W      = 5,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned INSTR_W        = 32,
    parameter int unsigned LINES          = 64,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic [WARP_ID_W-1:0] s_warp_id,
    input  logic [ADDR_W-1:0]    s_pc,
    input  logic                 s_tlast,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [WARP_ID_W-1:0] m_warp_id,
    output logic [INSTR_W-1:0]   m_instruction,
    output logic                 m_tlast,
    output logic                 m_error,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [ADDR_W-1:0]    mem_req_addr,
    input  logic                 mem_rsp_valid,
    input  logic [INSTR_W-1:0]   mem_rsp_data,
    input  logic                 flush,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
);
    localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned LSB_W = OFF_W + 2;
    localparam int unsigned TAG_W = ADDR_W - IDX_W - LSB_W;
    localparam int unsigned DEPTH = LINES * WORDS_PER_LINE;

    typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [INSTR_W-1:0]   r_data [DEPTH];
    logic [TAG_W-1:0]     r_tags [LINES];
    logic [LINES-1:0]     r_valid;

    logic                 r_live;
    logic [WARP_ID_W-1:0] r_warp;
    logic [TAG_W-1:0]     r_tag;
    logic [IDX_W-1:0]     r_idx;
    logic [OFF_W-1:0]     r_word;
    logic                 r_tlast;
    logic                 r_flushed;
    logic [OFF_W-1:0]     r_beat;
    logic [INSTR_W-1:0]   r_fill_word;

    logic [OFF_W-1:0]     w_word;
    logic [IDX_W-1:0]     w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic                 w_misalign;
    logic                 w_hit;
    logic                 w_accept;
    logic                 w_beat_fire;
    logic                 w_last_beat;

    assign w_word      = s_pc[OFF_W+1:2];
    assign w_idx       = s_pc[LSB_W+IDX_W-1:LSB_W];
    assign w_tag       = s_pc[ADDR_W-1:LSB_W+IDX_W];
    assign w_misalign  = (s_pc[1:0] != 2'b00);
    assign w_hit       = r_valid[w_idx] && (r_tags[w_idx] == w_tag);

    // r_live keeps s_tready low while reset is asserted
    assign s_tready    = r_live && (r_state == IDLE) && !flush && (!m_tvalid || m_tready);
    assign w_accept    = s_tvalid && s_tready;
    assign w_beat_fire = (r_state == FILL) && mem_rsp_valid;
    assign w_last_beat = w_beat_fire && (r_beat == OFF_W'(WORDS_PER_LINE - 1));

    assign mem_req_valid = (r_state == REQ);
    assign mem_req_addr  = {r_tag, r_idx, LSB_W'(0)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && !w_misalign && !w_hit) w_state_next = REQ;
            REQ:     if (mem_req_ready) w_state_next = FILL;
            FILL:    if (w_last_beat) w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Line storage carries no reset; r_valid gates every read
    always_ff @(posedge clk) begin
        if (w_beat_fire) r_data[{r_idx, r_beat}] <= mem_rsp_data;
        if (w_last_beat) r_tags[r_idx] <= r_tag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live      <= 1'b0;
            r_valid     <= '0;
            r_warp      <= '0;
            r_tag       <= '0;
            r_idx       <= '0;
            r_word      <= '0;
            r_tlast     <= 1'b0;
            r_flushed   <= 1'b0;
            r_beat      <= '0;
            r_fill_word <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_warp  <= s_warp_id;
                r_tag   <= w_tag;
                r_idx   <= w_idx;
                r_word  <= w_word;
                r_tlast <= s_tlast;
                if (!w_misalign && w_hit)  hit_count  <= hit_count + 32'd1;
                if (!w_misalign && !w_hit) miss_count <= miss_count + 32'd1;
            end
            // A flush anywhere inside a miss keeps the refilled line invalid
            if (w_accept)   r_flushed <= 1'b0;
            else if (flush) r_flushed <= 1'b1;
            if (flush)                          r_valid        <= '0;
            else if (w_last_beat && !r_flushed) r_valid[r_idx] <= 1'b1;
            if (r_state == REQ)   r_beat <= '0;
            else if (w_beat_fire) r_beat <= r_beat + OFF_W'(1);
            if (w_beat_fire && (r_beat == r_word)) r_fill_word <= mem_rsp_data;
        end
    end

    // Output register: loads on hit/misaligned accept or from RESP, else holds until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tvalid      <= 1'b0;
            m_warp_id     <= '0;
            m_instruction <= '0;
            m_tlast       <= 1'b0;
            m_error       <= 1'b0;
        end else if (w_accept && (w_misalign || w_hit)) begin
            m_tvalid      <= 1'b1;
            m_warp_id     <= s_warp_id;
            m_instruction <= w_misalign ? '0 : r_data[{w_idx, w_word}];
            m_tlast       <= s_tlast;
            m_error       <= w_misalign;
        end else if (r_state == RESP) begin
            m_tvalid      <= 1'b1;
            m_warp_id     <= r_warp;
            m_instruction <= r_fill_word;
            m_tlast       <= r_tlast;
            m_error       <= 1'b0;
        end else if (m_tready) begin
            m_tvalid      <= 1'b0;
        end
    end
endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Parametrised direct-mapped instruction cache between the warp scheduler and the decode stage.
- Accepts one fetch (warp id, PC) per handshake and returns the 32-bit instruction tagged with the same warp id.
- On a miss, fetches a whole line from the instruction memory port over a request/burst-response interface.
- Adds flush, misalignment error reporting, output backpressure and hit/miss counters.

Parameters:
- WARP_ID_W, 5, warp id width
- ADDR_W, 32, PC/byte-address width
- INSTR_W, 32, instruction/memory beat width
- LINES, 64, number of cache lines (power of 2, >=2)
- WORDS_PER_LINE, 4, instructions per line (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_tvalid  in  1  fetch request valid
- s_tready  out  1  cache can accept a fetch
- s_warp_id  in  WARP_ID_W  requesting warp
- s_pc  in  ADDR_W  fetch byte address
- s_tlast  in  1  sideband, passed through with the request
- m_tvalid  out  1  instruction valid
- m_tready  in  1  decode accepts instruction
- m_warp_id  out  WARP_ID_W  warp id of the returned instruction
- m_instruction  out  INSTR_W  fetched instruction
- m_tlast  out  1  sideband echo
- m_error  out  1  misaligned PC
- mem_req_valid  out  1  line fill request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  line-aligned byte address
- mem_rsp_valid  in  1  fill beat valid (cache always ready while in FILL)
- mem_rsp_data  in  INSTR_W  fill beat, ascending word order
- flush  in  1  invalidate all lines
- hit_count  out  32  hits since reset, wraps
- miss_count  out  32  misses since reset, wraps

Behaviour:
- Address split:
  - OFF_W = log2(WORDS_PER_LINE), IDX_W = log2(LINES).
  - word = s_pc[OFF_W+1:2], index = s_pc[OFF_W+IDX_W+1:OFF_W+2], tag = remaining upper bits.
- Storage: data array LINES x WORDS_PER_LINE x INSTR_W, tag array, valid bit per line.
- Reset: state IDLE, all valid bits cleared, counters 0, every output 0 (s_tready becomes 1 after reset release).
- s_tready = (state==IDLE) && !flush && (!m_tvalid || m_tready).
- FSM states: IDLE, REQ, FILL, RESP.
- IDLE, fetch accepted:
  - Latch warp id, PC and tlast.
  - Misaligned (s_pc[1:0]!=0): next cycle m_tvalid=1, m_error=1, m_instruction=0. No counter change, no fill.
  - Hit (valid && tag match): next cycle m_tvalid=1 with the stored word, m_error=0, hit_count+1. Latency 1 cycle.
  - Miss: miss_count+1, go to REQ.
- REQ: mem_req_valid=1, mem_req_addr={tag,index,OFF_W+2 zero bits}, held stable until mem_req_ready. Then go to FILL; mem_req_valid drops the next cycle.
- FILL:
  - Each mem_rsp_valid beat writes word k (k from 0 to WORDS_PER_LINE-1) of the line.
  - After the last beat: set tag, set valid (unless a flush occurred during this miss), go to RESP.
  - mem_rsp_valid outside FILL is ignored.
- RESP: m_tvalid=1 with the requested word (forwarded from the fill register), m_warp_id/m_tlast from the latch. Return to IDLE.
- Output hold: while m_tvalid && !m_tready, all m_* stay stable. m_tvalid drops after the handshake unless a new result is loaded the same cycle.
- flush:
  - Clears all valid bits in one cycle in any state and blocks acceptance that cycle.
  - During REQ/FILL: the in-flight fill completes and the requester still receives its instruction, but the line is left invalid.
- Counters increment only on the accept cycle; they wrap at 2^32.
- Async reset mid-fill: immediate return to IDLE, valid bits cleared, mem_req_valid=0. Later stale mem_rsp beats are ignored.

Test Plan:
- Reset, then fetch warp 3 pc 0x0000_1000 -> mem_req_addr=0x1000. Supply beats FE20_8FE3, 1111_1111, 2222_2222, 3333_3333 -> m_instruction=FE20_8FE3, m_warp_id=3, miss_count=1.
- Then fetch warp 7 pc 0x1004 -> m_tvalid exactly 1 cycle after accept, data 1111_1111, m_warp_id=7, hit_count=1, no mem_req.
- Fetch pc 0x1400 (same index 0, different tag) -> miss and refill. A following fetch of 0x1000 misses again: miss_count=3.
- Hit with m_tready low for 3 cycles -> m_* stable, s_tready=0, hit_count increments once. Handshake completes on the 4th cycle.
- flush pulsed during FILL of 0x2000 -> requester still receives the correct word; re-fetch of 0x2000 misses.
- Fetch pc 0x1002 -> m_error=1, m_instruction=0, no mem_req, counters unchanged. Assert rst_n low mid-FILL -> all outputs 0, next fetch of the line misses.
